// File: rtl/lsu.sv
// Load/store unit: turns decoder memory-access controls plus the ALU address
// into a single word-aligned bus transaction with byte enables, extracts and
// extends load data, flags misaligned/reserved accesses and bus timeouts, and
// returns a one-cycle completion pulse to the core.
module lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        mem_rd_en_i,
    input  logic        mem_wr_en_i,
    input  logic [1:0]  mem_acc_r_i,
    input  logic [1:0]  mem_acc_w_i,
    input  logic        mem_r_sext_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rd_data_o,
    output logic        mem_rd_valid_o,
    output logic        mem_wr_ready_o,
    output logic        mem_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Counter is at least 8 bits, wider only when the timeout needs it.
    localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    // The abort happens on the edge that would make the count reach
    // TIMEOUT_CYCLES, so the request is high for exactly that many cycles.
    localparam logic [CNT_W-1:0] TO_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state_q;
    logic             we_q;
    logic             err_q;
    logic             sext_q;
    logic [1:0]       size_q;
    logic [1:0]       lo_q;
    logic [31:0]      addr_q;
    logic [3:0]       be_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic [CNT_W-1:0] cnt_q;

    logic [1:0]       acc_size;
    logic             acc_bad;
    logic             timeout_hit;

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            SZ_B:    return 1'b0;
            SZ_H:    return lo[0];
            SZ_W:    return (lo != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            SZ_B:    return 4'b0001 << lo;
            SZ_H:    return 4'b0011 << lo;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_rep(input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            SZ_B:    return {4{wd[7:0]}};
            SZ_H:    return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] rd, input logic [1:0] sz,
                                             input logic [1:0] lo, input logic sx);
        logic [31:0]        shifted;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] res;
        shifted = rd >> {lo, 3'b000};
        b       = shifted[7:0];
        h       = lo[1] ? rd[31:16] : rd[15:0];
        case (sz)
            SZ_B: begin
                if (sx) res = b;
                else    res = {24'h0, b};
            end
            SZ_H: begin
                if (sx) res = h;
                else    res = {16'h0, h};
            end
            default: res = rd;
        endcase
        return res;
    endfunction

    assign acc_size    = mem_wr_en_i ? mem_acc_w_i : mem_acc_r_i;
    assign acc_bad     = is_misaligned(acc_size, mem_addr_i[1:0]);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

    // Access FSM with request capture, timeout counter and load data register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            sext_q  <= 1'b0;
            size_q  <= 2'b00;
            lo_q    <= 2'b00;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mem_wr_en_i || mem_rd_en_i) begin
                        we_q   <= mem_wr_en_i;
                        sext_q <= mem_r_sext_i;
                        size_q <= acc_size;
                        lo_q   <= mem_addr_i[1:0];
                        cnt_q  <= '0;
                        if (acc_bad) begin
                            // Rejected locally; the bus never sees it.
                            err_q   <= 1'b1;
                            state_q <= ST_DONE;
                            if (!mem_wr_en_i) rdata_q <= '0;
                        end else begin
                            err_q   <= 1'b0;
                            addr_q  <= {mem_addr_i[31:2], 2'b00};
                            be_q    <= byte_en(acc_size, mem_addr_i[1:0]);
                            wdata_q <= lane_rep(acc_size, mem_wdata_i);
                            state_q <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus_ack_i) begin
                        // Ack beats a simultaneous timeout.
                        err_q   <= 1'b0;
                        state_q <= ST_DONE;
                        if (!we_q) rdata_q <= load_ext(bus_rdata_i, size_q, lo_q, sext_q);
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                        if (!we_q) rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus_req_o      = (state_q == ST_REQ);
    assign bus_we_o       = we_q;
    assign bus_addr_o     = addr_q;
    assign bus_be_o       = be_q;
    assign bus_wdata_o    = wdata_q;
    assign mem_rd_data_o  = rdata_q;
    assign mem_rd_valid_o = (state_q == ST_DONE) && !we_q;
    assign mem_wr_ready_o = (state_q == ST_DONE) && we_q;
    assign mem_err_o      = (state_q == ST_DONE) && err_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: each access pushes its expected completion onto a
// scoreboard, which is popped and compared when the completion pulse appears.
module tb_lsu;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        mem_rd_en_i, mem_wr_en_i, mem_r_sext_i;
    logic [1:0]  mem_acc_r_i, mem_acc_w_i;
    logic [31:0] mem_addr_i, mem_wdata_i;
    logic [31:0] mem_rd_data_o;
    logic        mem_rd_valid_o, mem_wr_ready_o, mem_err_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
    logic [3:0]  bus_be_o;
    logic        bus_ack_i;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        is_store;
        logic        err;
        logic        chk_data;
        logic [31:0] data;
        int          lat;
        int          req_cyc;
        logic [31:0] baddr;
        logic [3:0]  be;
        logic        chk_wdata;
        logic [31:0] bwdata;
    } exp_t;

    exp_t sb[$];

    lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .mem_rd_en_i    (mem_rd_en_i),
        .mem_wr_en_i    (mem_wr_en_i),
        .mem_acc_r_i    (mem_acc_r_i),
        .mem_acc_w_i    (mem_acc_w_i),
        .mem_r_sext_i   (mem_r_sext_i),
        .mem_addr_i     (mem_addr_i),
        .mem_wdata_i    (mem_wdata_i),
        .mem_rd_data_o  (mem_rd_data_o),
        .mem_rd_valid_o (mem_rd_valid_o),
        .mem_wr_ready_o (mem_wr_ready_o),
        .mem_err_o      (mem_err_o),
        .bus_req_o      (bus_req_o),
        .bus_we_o       (bus_we_o),
        .bus_addr_o     (bus_addr_o),
        .bus_be_o       (bus_be_o),
        .bus_wdata_o    (bus_wdata_o),
        .bus_rdata_i    (bus_rdata_i),
        .bus_ack_i      (bus_ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic st, input logic err, input logic cd,
                                input logic [31:0] data, input int lat, input int rq,
                                input logic [31:0] ba, input logic [3:0] be,
                                input logic cw, input logic [31:0] bw);
        exp_t e;
        e.is_store = st;  e.err = err;     e.chk_data = cd; e.data = data;
        e.lat = lat;      e.req_cyc = rq;  e.baddr = ba;    e.be = be;
        e.chk_wdata = cw; e.bwdata = bw;
        return e;
    endfunction

    // Drive one access, act as bus slave (ack on REQ cycle ack_at, 0 = never),
    // and compare the completion against the scoreboard head.
    task automatic run(input string tag, input logic wr, input logic rd,
                       input logic [1:0] szw, input logic [1:0] szr, input logic sx,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rdat, input int ack_at);
        int   c;
        int   reqc;
        bit   done;
        exp_t e;
        mem_wr_en_i = wr;  mem_rd_en_i = rd;
        mem_acc_w_i = szw; mem_acc_r_i = szr; mem_r_sext_i = sx;
        mem_addr_i  = addr; mem_wdata_i = wd;
        bus_rdata_i = rdat; bus_ack_i = 1'b0;
        @(posedge clk_i); #1;
        c = 0; reqc = 0; done = 0;
        while (!done && c < 20) begin
            if (mem_rd_valid_o || mem_wr_ready_o) begin
                mem_wr_en_i = 1'b0; mem_rd_en_i = 1'b0; bus_ack_i = 1'b0;
                chk({tag, ":sb_depth"}, 32'(sb.size()), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk({tag, ":wr_ready"}, {31'd0, mem_wr_ready_o}, {31'd0, e.is_store});
                    chk({tag, ":rd_valid"}, {31'd0, mem_rd_valid_o}, {31'd0, !e.is_store});
                    chk({tag, ":err"}, {31'd0, mem_err_o}, {31'd0, e.err});
                    chk({tag, ":latency"}, 32'(c), 32'(e.lat));
                    chk({tag, ":req_cycles"}, 32'(reqc), 32'(e.req_cyc));
                    if (e.chk_data) chk({tag, ":rd_data"}, mem_rd_data_o, e.data);
                end
                done = 1;
            end else begin
                bus_ack_i = 1'b0;
                if (bus_req_o) begin
                    reqc++;
                    if (sb.size() > 0) begin
                        chk({tag, ":bus_we"}, {31'd0, bus_we_o}, {31'd0, sb[0].is_store});
                        chk({tag, ":bus_addr"}, bus_addr_o, sb[0].baddr);
                        chk({tag, ":bus_be"}, {28'd0, bus_be_o}, {28'd0, sb[0].be});
                        if (sb[0].chk_wdata) chk({tag, ":bus_wdata"}, bus_wdata_o, sb[0].bwdata);
                    end
                    bus_ack_i = (ack_at == reqc);
                end
                @(posedge clk_i); #1;
                c++;
            end
        end
        chk({tag, ":completed"}, {31'd0, done}, 32'd1);
        mem_wr_en_i = 1'b0; mem_rd_en_i = 1'b0; bus_ack_i = 1'b0;
        @(posedge clk_i); #1;
        chk({tag, ":pulse_end"}, {29'd0, mem_rd_valid_o, mem_wr_ready_o, mem_err_o}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn_i = 1'b0;
        mem_rd_en_i = 1'b0; mem_wr_en_i = 1'b0; mem_r_sext_i = 1'b0;
        mem_acc_r_i = 2'b00; mem_acc_w_i = 2'b00;
        mem_addr_i = '0; mem_wdata_i = '0; bus_rdata_i = '0; bus_ack_i = 1'b0;
        #2;
        chk("rst:bus_req", {31'd0, bus_req_o}, 32'd0);
        chk("rst:pulses", {29'd0, mem_rd_valid_o, mem_wr_ready_o, mem_err_o}, 32'd0);
        chk("rst:rd_data", mem_rd_data_o, 32'd0);
        chk("rst:bus_addr", bus_addr_o, 32'd0);
        chk("rst:bus_be_we", {27'd0, bus_we_o, bus_be_o}, 32'd0);
        chk("rst:bus_wdata", bus_wdata_o, 32'd0);
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        @(posedge clk_i); #1;

        sb.push_back(mk(1, 0, 0, 0, 1, 1, 32'h100, 4'b1111, 1, 32'hDEADBEEF));
        run("st_word", 1, 0, 2'b10, 2'b00, 0, 32'h100, 32'hDEADBEEF, 32'h0, 1);

        sb.push_back(mk(0, 0, 1, 32'hFFFFFF80, 1, 1, 32'h200, 4'b1000, 0, 0));
        run("ld_b_sext", 0, 1, 2'b00, 2'b00, 1, 32'h203, 32'h0, 32'h80123456, 1);

        sb.push_back(mk(0, 0, 1, 32'h00000080, 2, 2, 32'h200, 4'b1000, 0, 0));
        run("ld_b_zext", 0, 1, 2'b00, 2'b00, 0, 32'h203, 32'h0, 32'h80123456, 2);

        sb.push_back(mk(1, 0, 0, 0, 1, 1, 32'h300, 4'b1100, 1, 32'hABCDABCD));
        run("st_half_hi", 1, 0, 2'b01, 2'b00, 0, 32'h302, 32'h1234ABCD, 32'h0, 1);

        sb.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0, 4'b0000, 0, 0));
        run("ld_h_misal", 0, 1, 2'b00, 2'b01, 0, 32'h001, 32'h0, 32'h0, 1);

        sb.push_back(mk(0, 1, 1, 32'h0, 4, 4, 32'h500, 4'b1111, 0, 0));
        run("ld_w_timeout", 0, 1, 2'b00, 2'b10, 0, 32'h500, 32'h0, 32'hCAFEF00D, 0);

        sb.push_back(mk(0, 0, 1, 32'h13579BDF, 4, 4, 32'h504, 4'b1111, 0, 0));
        run("ld_w_ack_last", 0, 1, 2'b00, 2'b10, 0, 32'h504, 32'h0, 32'h13579BDF, 4);

        sb.push_back(mk(0, 0, 1, 32'hFFFF8001, 1, 1, 32'h600, 4'b1100, 0, 0));
        run("ld_h_sext", 0, 1, 2'b00, 2'b01, 1, 32'h602, 32'h0, 32'h80017FFF, 1);

        sb.push_back(mk(1, 0, 0, 0, 3, 3, 32'h700, 4'b0010, 1, 32'hA5A5A5A5));
        run("st_byte", 1, 0, 2'b00, 2'b00, 0, 32'h701, 32'h000000A5, 32'h0, 3);

        sb.push_back(mk(1, 1, 0, 0, 0, 0, 32'h0, 4'b0000, 0, 0));
        run("st_reserved", 1, 0, 2'b11, 2'b00, 0, 32'h800, 32'h55555555, 32'h0, 1);

        sb.push_back(mk(1, 1, 0, 0, 0, 0, 32'h0, 4'b0000, 0, 0));
        run("st_w_misal", 1, 0, 2'b10, 2'b00, 0, 32'h802, 32'h55555555, 32'h0, 1);

        sb.push_back(mk(1, 0, 0, 0, 1, 1, 32'h900, 4'b1111, 1, 32'h11223344));
        run("prio_store", 1, 1, 2'b10, 2'b00, 1, 32'h900, 32'h11223344, 32'hFFFFFFFF, 1);
        chk("rd_data_hold", mem_rd_data_o, 32'hFFFF8001);

        // Reset while the bus request is outstanding.
        mem_rd_en_i = 1'b1; mem_acc_r_i = 2'b10; mem_addr_i = 32'hA00;
        bus_ack_i = 1'b0;
        @(posedge clk_i); #1;
        chk("rst_mid:req_before", {31'd0, bus_req_o}, 32'd1);
        @(posedge clk_i); #3;
        rstn_i = 1'b0;
        mem_rd_en_i = 1'b0;
        #1;
        chk("rst_mid:req_async", {31'd0, bus_req_o}, 32'd0);
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            chk("rst_mid:no_pulse", {29'd0, mem_rd_valid_o, mem_wr_ready_o, bus_req_o}, 32'd0);
        end

        sb.push_back(mk(0, 0, 1, 32'h0BADCAFE, 1, 1, 32'hB00, 4'b1111, 0, 0));
        run("ld_after_rst", 0, 1, 2'b00, 2'b10, 0, 32'hB00, 32'h0, 32'h0BADCAFE, 1);

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
